// File: rtl/job_dispatcher.sv
// Initiator side of the go/kill/done worker handshake: runs a batch of worker
// jobs, aborting any run that overstays its timeout, and reports outcome counts.
module job_dispatcher #(
    parameter int COUNT_W    = 8,
    parameter int TIMEOUT_W  = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    input  logic [COUNT_W-1:0]   req_count,
    input  logic [TIMEOUT_W-1:0] req_timeout,
    output logic                 req_ready,
    output logic                 worker_go,
    output logic                 worker_kill,
    input  logic                 worker_done,
    output logic                 busy,
    output logic [COUNT_W-1:0]   run_idx,
    output logic [COUNT_W-1:0]   ok_count,
    output logic [COUNT_W-1:0]   kill_count,
    output logic                 batch_done
);

    // state    | meaning
    // S_IDLE   | waiting for a batch request
    // S_LAUNCH | worker_go pulse, timer loaded
    // S_WAIT   | waiting for worker_done or timeout
    // S_KILL   | worker_kill pulse, run counted as killed
    // S_GAP    | idle spacing before the next run
    // S_FINISH | batch_done pulse
    typedef enum logic [2:0] {
        S_IDLE, S_LAUNCH, S_WAIT, S_KILL, S_GAP, S_FINISH
    } state_t;

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    state_t               state_q;
    logic [COUNT_W-1:0]   runs_left_q;
    logic [COUNT_W-1:0]   run_idx_q;
    logic [COUNT_W-1:0]   ok_q;
    logic [COUNT_W-1:0]   kill_cnt_q;
    logic [TIMEOUT_W-1:0] t_q;
    logic [TIMEOUT_W-1:0] timer_q;
    logic [GAP_W-1:0]     gap_q;
    logic                 ready_q;
    logic                 busy_q;
    logic                 go_q;
    logic                 kill_q;
    logic                 bdone_q;

    // Outputs are registered alongside the state transition that implies them.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            runs_left_q <= '0;
            run_idx_q   <= '0;
            ok_q        <= '0;
            kill_cnt_q  <= '0;
            t_q         <= '0;
            timer_q     <= '0;
            gap_q       <= '0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            go_q        <= 1'b0;
            kill_q      <= 1'b0;
            bdone_q     <= 1'b0;
        end else begin
            go_q    <= 1'b0;
            kill_q  <= 1'b0;
            bdone_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        runs_left_q <= req_count;
                        t_q         <= req_timeout;
                        run_idx_q   <= '0;
                        ok_q        <= '0;
                        kill_cnt_q  <= '0;
                        ready_q     <= 1'b0;
                        busy_q      <= 1'b1;
                        if (req_count != '0) begin
                            state_q <= S_LAUNCH;
                            go_q    <= 1'b1;
                        end else begin
                            state_q <= S_FINISH;
                            bdone_q <= 1'b1;
                        end
                    end
                end
                S_LAUNCH: begin
                    timer_q <= t_q;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    // done wins over a timeout landing in the same cycle
                    if (worker_done) begin
                        if (ok_q != '1) ok_q <= ok_q + 1'b1;
                        run_idx_q   <= run_idx_q + 1'b1;
                        runs_left_q <= runs_left_q - 1'b1;
                        gap_q       <= GAP_W'(GAP_CYCLES - 1);
                        state_q     <= S_GAP;
                    end else if (t_q != '0 && timer_q == TIMEOUT_W'(1)) begin
                        state_q <= S_KILL;
                        kill_q  <= 1'b1;
                    end else if (t_q != '0) begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
                S_KILL: begin
                    if (kill_cnt_q != '1) kill_cnt_q <= kill_cnt_q + 1'b1;
                    run_idx_q   <= run_idx_q + 1'b1;
                    runs_left_q <= runs_left_q - 1'b1;
                    gap_q       <= GAP_W'(GAP_CYCLES - 1);
                    state_q     <= S_GAP;
                end
                S_GAP: begin
                    if (gap_q == '0) begin
                        if (runs_left_q != '0) begin
                            state_q <= S_LAUNCH;
                            go_q    <= 1'b1;
                        end else begin
                            state_q <= S_FINISH;
                            bdone_q <= 1'b1;
                        end
                    end else begin
                        gap_q <= gap_q - 1'b1;
                    end
                end
                S_FINISH: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready   = ready_q;
    assign busy        = busy_q;
    assign worker_go   = go_q;
    assign worker_kill = kill_q;
    assign batch_done  = bdone_q;
    assign run_idx     = run_idx_q;
    assign ok_count    = ok_q;
    assign kill_count  = kill_cnt_q;

endmodule

// File: tb/tb_job_dispatcher.sv
// Scoreboard bench for job_dispatcher: expected go/kill/batch_done events are
// queued per batch and matched by a monitor as the DUT pulses them.
module tb_job_dispatcher;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       worker_done = 1'b0;
    logic [7:0] req_count = '0;
    logic [7:0] req_timeout = '0;
    logic       req_ready, worker_go, worker_kill, busy, batch_done;
    logic [7:0] run_idx, ok_count, kill_count;

    job_dispatcher #(.COUNT_W(8), .TIMEOUT_W(8), .GAP_CYCLES(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_count   (req_count),
        .req_timeout (req_timeout),
        .req_ready   (req_ready),
        .worker_go   (worker_go),
        .worker_kill (worker_kill),
        .worker_done (worker_done),
        .busy        (busy),
        .run_idx     (run_idx),
        .ok_count    (ok_count),
        .kill_count  (kill_count),
        .batch_done  (batch_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int kind;   // 0 go, 1 kill, 2 batch_done
        int cyc;
        int ok;
        int kl;
        int ri;
    } ev_t;

    ev_t q[$];
    int  n_chk  = 0;
    int  n_fail = 0;
    int  base   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : monitor
        int  kind;
        ev_t e;
        if (worker_go || worker_kill)
            chk("go_kill_exclusive", int'(worker_go && worker_kill), 0);
        while (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            n_chk++;
            n_fail++;
            $display("FAIL missed_event: kind %0d expected at cycle %0d, not seen by cycle %0d",
                     e.kind, e.cyc, cyc);
        end
        kind = worker_go ? 0 : worker_kill ? 1 : batch_done ? 2 : -1;
        if (kind >= 0) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_event: kind %0d at cycle %0d, none expected", kind, cyc);
            end else begin
                e = q.pop_front();
                chk("event_kind", kind, e.kind);
                chk("event_cycle", cyc, e.cyc);
                if (kind == 2) begin
                    chk("ok_count", int'(ok_count), e.ok);
                    chk("kill_count", int'(kill_count), e.kl);
                    chk("run_idx", int'(run_idx), e.ri);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic expect_ev(input int kind, input int rel, input int ok, input int kl, input int ri);
        ev_t e;
        e.kind = kind;
        e.cyc  = base + rel;
        e.ok   = ok;
        e.kl   = kl;
        e.ri   = ri;
        q.push_back(e);
    endtask

    task automatic request(input int cnt, input int to);
        req_count   = 8'(cnt);
        req_timeout = 8'(to);
        req_valid   = 1'b1;
        tick();
        req_valid   = 1'b0;
    endtask

    task automatic done_at(input int rel);
        wait_to(base + rel);
        worker_done = 1'b1;
        tick();
        worker_done = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (q.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        if (q.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_timeout: %0d events outstanding, expected 0", q.size());
            q.delete();
        end
        repeat (3) tick();
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_req_ready"}, int'(req_ready), 1);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_run_idx"}, int'(run_idx), 0);
        chk({tag, "_ok_count"}, int'(ok_count), 0);
        chk({tag, "_kill_count"}, int'(kill_count), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset and idle; a stray done in IDLE must not move anything
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        repeat (2) tick();
        worker_done = 1'b1;
        tick();
        worker_done = 1'b0;
        repeat (2) tick();
        chk_idle("reset");
        chk("reset_go", int'(worker_go), 0);
        chk("reset_kill", int'(worker_kill), 0);
        chk("reset_batch_done", int'(batch_done), 0);

        // one run, done at cycle 5; extra done during GAP is ignored
        base = cyc;
        expect_ev(0, 1, 0, 0, 0);
        expect_ev(2, 8, 1, 0, 1);
        request(1, 10);
        chk("t1_busy", int'(busy), 1);
        chk("t1_req_ready", int'(req_ready), 0);
        done_at(5);
        done_at(7);
        drain(40);

        // two runs, both time out
        base = cyc;
        expect_ev(0, 1, 0, 0, 0);
        expect_ev(1, 6, 0, 0, 0);
        expect_ev(0, 9, 0, 0, 0);
        expect_ev(1, 14, 0, 0, 0);
        expect_ev(2, 17, 0, 2, 2);
        request(2, 4);
        drain(40);

        // done in the last WAIT cycle counts as success
        base = cyc;
        expect_ev(0, 1, 0, 0, 0);
        expect_ev(2, 7, 1, 0, 1);
        request(1, 3);
        done_at(4);
        drain(40);

        // empty batch
        base = cyc;
        expect_ev(2, 1, 0, 0, 0);
        request(0, 5);
        chk("t4_req_ready_c1", int'(req_ready), 0);
        wait_to(base + 2);
        chk("t4_req_ready_c2", int'(req_ready), 1);
        chk("t4_busy_c2", int'(busy), 0);
        drain(10);

        // no timeout, reset mid-WAIT, then a fresh batch
        base = cyc;
        expect_ev(0, 1, 0, 0, 0);
        request(3, 0);
        wait_to(base + 20);
        chk("t5_busy_wait", int'(busy), 1);
        reset = 1'b1;
        tick();
        chk_idle("t5_after_reset");
        reset = 1'b0;
        repeat (3) tick();
        chk("t5_q_empty", q.size(), 0);
        base = cyc;
        expect_ev(0, 1, 0, 0, 0);
        expect_ev(1, 4, 0, 0, 0);
        expect_ev(2, 7, 0, 1, 1);
        request(1, 2);
        drain(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/job_dispatcher.md
Name: job_dispatcher

Overview:
- Initiator side of the go/kill/done worker handshake used by the team's worker state machines.
- Accepts a batch request (run count plus timeout) and drives one worker through that many runs. Each run is started with a one-cycle go pulse; the block then waits for done.
- If done does not arrive within the timeout, the block aborts the run with a one-cycle kill pulse.
- Reports per-batch success and kill counts and signals batch completion.

Parameters:
- COUNT_W, 8, width of req_count, run_idx, ok_count, kill_count.
- TIMEOUT_W, 8, width of req_timeout and the internal timeout timer.
- GAP_CYCLES, 2, idle cycles between the end of one run and the next go. Legal values are ≥1.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  batch request valid.
- req_count  in  COUNT_W  number of runs in the batch.
- req_timeout  in  TIMEOUT_W  maximum WAIT cycles per run; 0 means no timeout.
- req_ready  out  1  high only in IDLE.
- worker_go  out  1  one-cycle start pulse to the worker.
- worker_kill  out  1  one-cycle abort pulse to the worker.
- worker_done  in  1  completion pulse from the worker.
- busy  out  1  high in every state except IDLE.
- run_idx  out  COUNT_W  number of runs finished (done or killed) in the current batch.
- ok_count  out  COUNT_W  runs ended by worker_done.
- kill_count  out  COUNT_W  runs ended by kill.
- batch_done  out  1  one-cycle pulse when the batch completes.

Behaviour:
- All outputs are Moore-decoded from registered state and counters. Inputs are sampled on the rising edge of clk.
- Reset values: state=IDLE; req_ready=1; busy, worker_go, worker_kill and batch_done all 0; run_idx, ok_count, kill_count, timer and runs_left all 0.
- States are IDLE, LAUNCH, WAIT, KILL, GAP, FINISH.
- IDLE:
  - On req_valid at a clock edge, the block latches runs_left=req_count and T=req_timeout, and clears run_idx, ok_count and kill_count.
  - If req_count≠0, next state is LAUNCH. If req_count=0, next state is FINISH.
- LAUNCH: worker_go=1 for exactly this cycle; timer←T; next state is WAIT.
- WAIT:
  - If worker_done is high: ok_count++, run_idx++, runs_left--, next state is GAP.
  - Else if T≠0 and timer=1: next state is KILL.
  - Else: timer decrements (it holds when T=0); stay in WAIT.
  - WAIT lasts at most T cycles. worker_done in the last WAIT cycle counts as success; done has priority over timeout.
- KILL: worker_kill=1 for exactly this cycle; kill_count++, run_idx++, runs_left--; next state is GAP.
- GAP:
  - Lasts exactly GAP_CYCLES cycles.
  - Then the next state is LAUNCH if runs_left≠0, otherwise FINISH.
- FINISH: batch_done=1 for one cycle; next state is IDLE.
- worker_done is ignored in every state except WAIT. It never changes a counter there.
- req_valid is ignored outside IDLE. A new request is accepted no earlier than the cycle after FINISH.
- ok_count and kill_count saturate at all-ones and never wrap.
- Timing for request accept edge at cycle 0 and T>0:
  - worker_go in cycle 1.
  - WAIT in cycles 2..T+1.
  - worker_kill in cycle T+2 if no done.
  - After the last run's GAP, FINISH follows immediately.
- Reset asserted in any state returns the block to IDLE at the next edge:
  - worker_go and worker_kill are low from that edge on.
  - No kill is issued for an in-flight run; the worker shares reset.
  - Counters clear.
- worker_go and worker_kill are never high in the same cycle. Each is never high for two consecutive cycles.

Test Plan:
- Reset for 2 cycles, then idle 5 cycles -> req_ready=1; busy, worker_go, worker_kill and batch_done all 0; counters 0.
- Request count=1, timeout=10 accepted at cycle 0; worker_done at cycle 5 -> worker_go at cycle 1 only. GAP at cycles 6–7, batch_done at cycle 8, ok_count=1, kill_count=0, no worker_kill.
- Request count=2, timeout=4, worker_done never asserted -> go at cycles 1 and 9, kill at cycles 6 and 14. batch_done at cycle 17, kill_count=2, run_idx=2.
- Request count=1, timeout=3; worker_done at cycle 4 (last WAIT cycle) -> success: ok_count=1, no worker_kill.
- Request count=0 -> batch_done at cycle 1, no worker_go, req_ready back to 1 at cycle 2.
- Request count=3, timeout=0; reset asserted at cycle 20 while in WAIT -> IDLE at cycle 21, no worker_kill, counters 0. A new request is then accepted normally.
